// File: rtl/coin_pkg.sv
// Shared definitions for the nickel/dime payout dispenser: FSM encodings,
// coin unit and default widths.
package coin_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PAY  = 2'b01,
    S_WAIT = 2'b10,
    S_FIN  = 2'b11
  } state_t;

  localparam int COIN_UNIT_CENTS = 5;
  localparam int DEF_AMT_W       = 4;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/coin_inv_counter.sv
// Saturating coin inventory counter. A simultaneous inc and dec cancel out,
// so a refill during an eject of the same coin leaves the count unchanged.
module coin_inv_counter #(
  parameter int W    = 8,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX_COUNT = '1;

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= W'(INIT);
    end else if (i_inc && !i_dec && (r_count != MAX_COUNT)) begin
      r_count <= r_count + W'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/coin_dispenser.sv
// Dime-first greedy payout engine: checks a request against the registered
// inventory, then ejects one coin per PAY cycle with GAP idle cycles between.
module coin_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W        = DEF_AMT_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int INIT_NICKELS = 16,
  parameter int INIT_DIMES   = 16,
  parameter int GAP          = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill_n,
  input  logic             refill_d,
  output logic             ready,
  output logic             n_out,
  output logic             d_out,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] nickels,
  output logic [CNT_W-1:0] dimes,
  output logic [1:0]       state
);

  // Feasibility arithmetic runs one bit wider than the larger operand.
  localparam int SW = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;
  localparam logic [3:0] GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           r_state;
  logic [AMT_W-1:0] r_remaining;
  logic             r_rej;
  logic [3:0]       r_gap;

  logic [SW-1:0]    w_half;
  logic [SW-1:0]    w_dimes_x;
  logic [SW-1:0]    w_d_use;
  logic [SW-1:0]    w_need_n;
  logic             w_feasible;
  logic             w_d_eject;
  logic             w_n_eject;
  logic [AMT_W-1:0] w_rem_next;

  assign w_half     = SW'(amount >> 1);
  assign w_dimes_x  = SW'(dimes);
  assign w_d_use    = (w_half < w_dimes_x) ? w_half : w_dimes_x;
  assign w_need_n   = SW'(amount) - (w_d_use << 1);
  assign w_feasible = (w_need_n <= SW'(nickels));

  assign w_d_eject  = (r_state == S_PAY) && (r_remaining >= AMT_W'(2)) && (dimes != '0);
  assign w_n_eject  = (r_state == S_PAY) && !w_d_eject;
  assign w_rem_next = w_d_eject ? (r_remaining - AMT_W'(2)) : (r_remaining - AMT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_rej       <= 1'b0;
      r_gap       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_remaining <= amount;
            if (amount == '0) begin
              r_rej   <= 1'b0;
              r_state <= S_FIN;
            end else if (w_feasible) begin
              r_rej   <= 1'b0;
              r_state <= S_PAY;
            end else begin
              r_rej   <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_PAY: begin
          r_remaining <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state <= S_FIN;
          end else if (GAP > 0) begin
            r_gap   <= GAP_M1;
            r_state <= S_WAIT;
          end else begin
            r_state <= S_PAY;
          end
        end
        S_WAIT: begin
          if (r_gap == '0) begin
            r_state <= S_PAY;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        S_FIN: begin
          r_remaining <= '0;
          r_rej       <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  coin_inv_counter #(
    .W    (CNT_W),
    .INIT (INIT_NICKELS)
  ) u_nickels (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (refill_n),
    .i_dec   (w_n_eject),
    .o_count (nickels)
  );

  coin_inv_counter #(
    .W    (CNT_W),
    .INIT (INIT_DIMES)
  ) u_dimes (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (refill_d),
    .i_dec   (w_d_eject),
    .o_count (dimes)
  );

  assign ready = (r_state == S_IDLE);
  assign n_out = w_n_eject;
  assign d_out = w_d_eject;
  assign done  = (r_state == S_FIN) && !r_rej;
  assign err   = (r_state == S_FIN) && r_rej;
  assign state = r_state;

endmodule

// File: tb/tb_coin_dispenser.sv
// Bench for coin_dispenser: two instances (GAP=1 with 16/16 inventory, GAP=0
// with 5 nickels / 1 dime), per-cycle expected output words in a queue.
module tb_coin_dispenser;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PAY  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_FIN  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       refill_n;
  logic       refill_d;
  logic       sel;
  logic [3:0] amount;

  logic       req1, rn1, rd1, ready1, n1, d1, done1, err1;
  logic [7:0] nick1, dime1;
  logic [1:0] st1;
  logic       req0, rn0, rd0, ready0, n0, d0, done0, err0;
  logic [7:0] nick0, dime0;
  logic [1:0] st0;

  logic       obs_ready, obs_n, obs_d, obs_done, obs_err;
  logic [7:0] obs_nick, obs_dime;
  logic [1:0] obs_state;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];
  int model_n[2];
  int model_d[2];

  typedef struct {
    logic        sel;
    logic [3:0]  amt;
    int          ncoins;
    logic [15:0] dmask;
    logic        rej;
    int          end_n;
    int          end_d;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  assign req1 = req & sel;
  assign rn1  = refill_n & sel;
  assign rd1  = refill_d & sel;
  assign req0 = req & ~sel;
  assign rn0  = refill_n & ~sel;
  assign rd0  = refill_d & ~sel;

  coin_dispenser #(
    .AMT_W(4), .CNT_W(8), .INIT_NICKELS(16), .INIT_DIMES(16), .GAP(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .amount(amount), .refill_n(rn1), .refill_d(rd1),
    .ready(ready1), .n_out(n1), .d_out(d1), .done(done1), .err(err1),
    .nickels(nick1), .dimes(dime1), .state(st1)
  );

  coin_dispenser #(
    .AMT_W(4), .CNT_W(8), .INIT_NICKELS(5), .INIT_DIMES(1), .GAP(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .amount(amount), .refill_n(rn0), .refill_d(rd0),
    .ready(ready0), .n_out(n0), .d_out(d0), .done(done0), .err(err0),
    .nickels(nick0), .dimes(dime0), .state(st0)
  );

  always_comb begin
    obs_ready = sel ? ready1 : ready0;
    obs_n     = sel ? n1     : n0;
    obs_d     = sel ? d1     : d0;
    obs_done  = sel ? done1  : done0;
    obs_err   = sel ? err1   : err0;
    obs_nick  = sel ? nick1  : nick0;
    obs_dime  = sel ? dime1  : dime0;
    obs_state = sel ? st1    : st0;
  end

  function automatic logic [6:0] mk(logic [1:0] st, logic rdy, logic n, logic d, logic dn, logic er);
    return {st, rdy, n, d, dn, er};
  endfunction

  function automatic logic [6:0] obs_word();
    return {obs_state, obs_ready, obs_n, obs_d, obs_done, obs_err};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int en, input int ed);
    check({tag, "_word"}, 32'(obs_word()), 32'(mk(ST_IDLE, 1, 0, 0, 0, 0)));
    check({tag, "_nickels"}, 32'(obs_nick), 32'(en));
    check({tag, "_dimes"}, 32'(obs_dime), 32'(ed));
  endtask

  // Word layout: {state[1:0], ready, n_out, d_out, done, err}.
  task automatic run_txn(input int tag, input logic s, input logic [3:0] amt, input int ncoins,
                         input logic [15:0] dmask, input logic rej,
                         input logic hold_req, input logic hold_refill_d);
    int idx;
    int gap;
    int cyc;
    logic [6:0] w;
    idx = s ? 1 : 0;
    gap = s ? 1 : 0;
    sel = s;
    @(negedge clk);
    check($sformatf("t%0d_ready_before", tag), 32'(obs_ready), 32'd1);
    check($sformatf("t%0d_nickels_before", tag), 32'(obs_nick), 32'(model_n[idx]));
    check($sformatf("t%0d_dimes_before", tag), 32'(obs_dime), 32'(model_d[idx]));
    amount = amt;
    req    = 1'b1;
    if (rej || ncoins == 0) begin
      exp_q.push_back(mk(ST_FIN, 0, 0, 0, !rej, rej));
    end else begin
      for (int i = 0; i < ncoins; i++) begin
        exp_q.push_back(mk(ST_PAY, 0, !dmask[i], dmask[i], 0, 0));
        if (i < ncoins - 1)
          for (int g = 0; g < gap; g++) exp_q.push_back(mk(ST_WAIT, 0, 0, 0, 0, 0));
      end
      exp_q.push_back(mk(ST_FIN, 0, 0, 0, 1, 0));
    end
    exp_q.push_back(mk(ST_IDLE, 1, 0, 0, 0, 0));
    if (hold_req) exp_q.push_back(mk(ST_IDLE, 1, 0, 0, 0, 0));
    @(posedge clk);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      w = exp_q.pop_front();
      check($sformatf("t%0d_c%0d_word", tag, cyc), 32'(obs_word()), 32'(w));
      check($sformatf("t%0d_c%0d_nickels", tag, cyc), 32'(obs_nick), 32'(model_n[idx]));
      check($sformatf("t%0d_c%0d_dimes", tag, cyc), 32'(obs_dime), 32'(model_d[idx]));
      req      = hold_req && (cyc == 1);
      refill_d = hold_refill_d && !w[4];
      model_d[idx] = model_d[idx] + int'(refill_d) - int'(w[2]);
      model_n[idx] = model_n[idx] - int'(w[3]);
    end
    req      = 1'b0;
    refill_d = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    req      = 1'b0;
    refill_n = 1'b0;
    refill_d = 1'b0;
    amount   = '0;
    sel      = 1'b1;
    model_n[1] = 16; model_d[1] = 16;
    model_n[0] = 5;  model_d[0] = 1;

    vecs[0] = '{1'b1, 4'd3,  2, 16'h0001, 1'b0, 15, 15};
    vecs[1] = '{1'b0, 4'd5,  4, 16'h0001, 1'b0, 2,  0};
    vecs[2] = '{1'b0, 4'd3,  0, 16'h0000, 1'b1, 2,  0};
    vecs[3] = '{1'b0, 4'd2,  2, 16'h0000, 1'b0, 0,  0};
    vecs[4] = '{1'b0, 4'd1,  0, 16'h0000, 1'b1, 0,  0};
    vecs[5] = '{1'b1, 4'd4,  2, 16'h0003, 1'b0, 15, 13};
    vecs[6] = '{1'b1, 4'd15, 8, 16'h007F, 1'b0, 14, 6};
    vecs[7] = '{1'b1, 4'd15, 9, 16'h003F, 1'b0, 11, 0};
    vecs[8] = '{1'b1, 4'd1,  1, 16'h0000, 1'b0, 10, 0};

    repeat (2) @(negedge clk);
    check_idle("rst_u1", 16, 16);
    sel = 1'b0;
    @(negedge clk);
    check_idle("rst_u0", 5, 1);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_rst_u0", 5, 1);

    for (int i = 0; i < 9; i++) begin
      run_txn(i, vecs[i].sel, vecs[i].amt, vecs[i].ncoins, vecs[i].dmask, vecs[i].rej, 1'b0, 1'b0);
      check($sformatf("t%0d_end_nickels", i), 32'(obs_nick), 32'(vecs[i].end_n));
      check($sformatf("t%0d_end_dimes", i), 32'(obs_dime), 32'(vecs[i].end_d));
    end

    // Nickel counter saturation on the GAP=1 instance.
    sel = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (i % 50 == 0) check($sformatf("sat_i%0d", i), 32'(obs_nick), 32'(model_n[1]));
      refill_n = 1'b1;
      model_n[1] = (model_n[1] < 255) ? model_n[1] + 1 : 255;
    end
    @(negedge clk);
    refill_n = 1'b0;
    check("sat_255", 32'(obs_nick), 32'd255);
    @(negedge clk);
    check("sat_hold_255", 32'(obs_nick), 32'd255);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_n[1] = 16; model_d[1] = 16;
    model_n[0] = 5;  model_d[0] = 1;
    @(negedge clk);
    check_idle("rst2_u1", 16, 16);

    // amount=0 with req held through the busy cycle.
    run_txn(20, 1'b1, 4'd0, 0, 16'h0000, 1'b0, 1'b1, 1'b0);
    // amount=3 with refill_d held during the payout: dimes stays 16 on the eject edge.
    run_txn(21, 1'b1, 4'd3, 2, 16'h0001, 1'b0, 1'b0, 1'b1);
    check("refill_end_dimes", 32'(obs_dime), 32'd19);
    check("refill_end_nickels", 32'(obs_nick), 32'd15);

    // Reset in cycle 2 of an amount=6 payout.
    sel = 1'b1;
    @(negedge clk);
    amount = 4'd6;
    req    = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("mid_c1_word", 32'(obs_word()), 32'(mk(ST_PAY, 0, 0, 1, 0, 0)));
    @(negedge clk);
    check("mid_c2_word", 32'(obs_word()), 32'(mk(ST_WAIT, 0, 0, 0, 0, 0)));
    #1 rst = 1'b1;
    #1;
    check_idle("mid_rst", 16, 16);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_hold", 32'(obs_word()), 32'(mk(ST_IDLE, 1, 0, 0, 0, 0)));
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle($sformatf("mid_after_%0d", i), 16, 16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_dispenser.md
# coin_dispenser

Change/payout dispenser that drives the nickel and dime eject lines: the transmit side of the nickel/dime coin interface consumed by the vending-machine sequencer. On a request it pays out an amount in 5-cent units, one coin per pulse, dime-first greedy. It keeps its own nickel and dime inventory and rejects requests it cannot pay exactly. It sits between the vend controller (payout requests) and the coin-eject mechanism.

## Interface
- AMT_W, 4, width of `amount` (units of 5 cents)
- CNT_W, 8, width of each inventory counter
- INIT_NICKELS, 16, nickel inventory after reset
- INIT_DIMES, 16, dime inventory after reset
- GAP, 1, idle cycles between consecutive coin pulses (0..15; 0 = back-to-back)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  1  payout request; accepted when `req & ready`
- amount  in  AMT_W  payout in nickel units (3 = 15 cents); sampled only on accept
- refill_n  in  1  add one nickel to inventory this cycle
- refill_d  in  1  add one dime to inventory this cycle
- ready  out  1  idle, can accept a request
- n_out  out  1  one-cycle nickel eject pulse
- d_out  out  1  one-cycle dime eject pulse
- done  out  1  one-cycle pulse: payout complete
- err  out  1  one-cycle pulse: request rejected
- nickels  out  CNT_W  current nickel inventory
- dimes  out  CNT_W  current dime inventory
- state  out  2  current FSM state (debug)

## Operation
- States: IDLE=00, PAY=01, WAIT=10, FIN=11.
- IDLE: `ready`=1. On accept, latch `amount` into `remaining` and evaluate feasibility from the registered inventory: d_use = min(amount>>1, dimes); need_n = amount − 2·d_use; feasible iff need_n ≤ nickels.
  - Feasible, amount>0: go to PAY.
  - amount=0: go to FIN with `done`.
  - Infeasible: go to FIN with `err`. No coins are ejected and inventory is unchanged.
- PAY: exactly one coin per PAY cycle.
  - If remaining ≥ 2 and dimes > 0: assert `d_out`, remaining −= 2, dimes −= 1.
  - Otherwise: assert `n_out`, remaining −= 1, nickels −= 1.
  - Next state: FIN if the new remaining = 0; else WAIT if GAP > 0; else PAY.
- WAIT: hold GAP cycles with no pulses, then return to PAY.
- FIN: one cycle. Assert `done`, or `err` for a rejected request (never both). Then go to IDLE.
- `req` is ignored whenever `ready`=0.
- Refill:
  - Each refill input increments its counter any cycle, saturating at 2^CNT_W−1.
  - A refill and an eject of the same coin type in the same cycle leave the count unchanged.
  - A refill in the accept cycle is not counted in the feasibility check.
- Ejects never underflow inventory; this follows from the feasibility check plus greedy order.
- `n_out` and `d_out` are never both high.

## Timing
- Reset values: state=00, ready=1, n_out=d_out=done=err=0, nickels=INIT_NICKELS, dimes=INIT_DIMES, remaining=0.
- Reset mid-payout aborts immediately: no further pulses, and inventory returns to INIT values.
- Accept at cycle 0. First coin appears in cycle 1, then one coin every GAP+1 cycles.
- After the last coin in cycle k: `done` in cycle k+1, `ready`=1 in cycle k+2.
- Rejected request or amount=0: `err` or `done` in cycle 1, `ready`=1 in cycle 2.
- Total latency from accept to `done` = (coins−1)·(GAP+1) + 2 cycles.
- Coin, done and err outputs are decoded from registered state, remaining and inventory. Inventory outputs are registered.

## Structure
- Shared package `coin_pkg`:
  - state encodings (IDLE/PAY/WAIT/FIN);
  - coin unit constant (5 cents);
  - default AMT_W/CNT_W.
- Sub-module `coin_inv_counter`: saturating up/down counter with an inc/dec pair and a reset load value. It is instantiated once for nickels and once for dimes.
- FSM, `remaining` register and feasibility logic stay in `coin_dispenser`.

## Test plan
- Reset, dimes=16, nickels=16, GAP=1, amount=3 → d_out in cycle 1, n_out in cycle 3, done in cycle 4, ready in cycle 5; dimes=15, nickels=15.
- dimes=0, nickels=2, amount=3 → err in cycle 1; no n_out/d_out; inventory unchanged; ready in cycle 2.
- dimes=1, nickels=5, GAP=0, amount=5 → pulses d, n, n, n in cycles 1–4 with no gaps; done in cycle 5; dimes=0, nickels=2.
- amount=0 → done in cycle 1, no coins; `req` held high during the busy cycle is ignored, with no second accept before ready returns.
- refill_d held high in every cycle of the scenario-1 payout → dimes stays at 16 on the dime-eject cycle, and a counter at 255 stays at 255 on refill.
- Assert rst in cycle 2 of an amount=6 payout → all outputs at reset values immediately, no further pulses, inventory back to INIT values.
